// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at accept and committed when the latency counter expires.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(8);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e              state;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [OP_W-1:0]     pend_op, pend_op_d;
  logic                pend_zero, pend_zero_d;
  logic [DATA_W-1:0]   res_hi, res_hi_d, res_lo, res_lo_d;
  logic [DATA_W-1:0]   hi_d, lo_d;

  logic                is_md_op, rt_zero, pend_is_div;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   div_u, mag_a, mag_b, mag_b_safe;
  logic [DATA_W-1:0]   quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;

  assign state       = (cnt != '0) ? S_BUSY : S_IDLE;
  assign busy        = (state == S_BUSY);
  assign is_md_op    = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign rt_zero     = (rt_data == '0);
  assign pend_is_div = (pend_op == OP_DIV) || (pend_op == OP_DIVU);

  // Sign-extended operands give the signed product in the low 64 bits.
  assign prod_s = {{DATA_W{rs_data[DATA_W-1]}}, rs_data} * {{DATA_W{rt_data[DATA_W-1]}}, rt_data};
  assign prod_u = {DATA_W'(0), rs_data} * {DATA_W'(0), rt_data};

  // Divisor forced to 1 on zero so the datapath never divides by zero; commit is skipped instead.
  assign div_u      = rt_zero ? DATA_W'(1) : rt_data;
  assign quo_u      = rs_data / div_u;
  assign rem_u      = rs_data % div_u;
  assign mag_a      = rs_data[DATA_W-1] ? (~rs_data + DATA_W'(1)) : rs_data;
  assign mag_b      = rt_data[DATA_W-1] ? (~rt_data + DATA_W'(1)) : rt_data;
  assign mag_b_safe = rt_zero ? DATA_W'(1) : mag_b;
  assign quo_m      = mag_a / mag_b_safe;
  assign rem_m      = mag_a % mag_b_safe;
  assign quo_s      = (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]) ? (~quo_m + DATA_W'(1)) : quo_m;
  assign rem_s      = rs_data[DATA_W-1] ? (~rem_m + DATA_W'(1)) : rem_m;

  // State and architectural register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      pend_op   <= '0;
      pend_zero <= 1'b0;
      res_hi    <= '0;
      res_lo    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      cnt       <= cnt_d;
      pend_op   <= pend_op_d;
      pend_zero <= pend_zero_d;
      res_hi    <= res_hi_d;
      res_lo    <= res_lo_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

  // Next-state: accept or MT in IDLE; count down and commit in BUSY.
  always_comb begin
    cnt_d       = cnt;
    pend_op_d   = pend_op;
    pend_zero_d = pend_zero;
    res_hi_d    = res_hi;
    res_lo_d    = res_lo;
    hi_d        = hi;
    lo_d        = lo;
    case (state)
      S_IDLE: begin
        if (!req) begin
          if (start && is_md_op) begin
            pend_op_d   = md_op;
            pend_zero_d = rt_zero;
            case (md_op)
              OP_MULT: begin
                {res_hi_d, res_lo_d} = prod_s;
                cnt_d                = CNT_W'(MULT_CYCLES);
              end
              OP_MULTU: begin
                {res_hi_d, res_lo_d} = prod_u;
                cnt_d                = CNT_W'(MULT_CYCLES);
              end
              OP_DIV: begin
                res_hi_d = rem_s;
                res_lo_d = quo_s;
                cnt_d    = CNT_W'(DIV_CYCLES);
              end
              default: begin
                res_hi_d = rem_u;
                res_lo_d = quo_u;
                cnt_d    = CNT_W'(DIV_CYCLES);
              end
            endcase
          end else if (md_op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (md_op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt - CNT_W'(1);
        if ((cnt == CNT_W'(1)) && !(pend_is_div && pend_zero)) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: ;
    endcase
  end

  // MFHI/MFLO read port.
  always_comb begin
    md_out = '0;
    if (md_op == OP_MFHI)      md_out = hi;
    else if (md_op == OP_MFLO) md_out = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, req;
  logic [3:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic        busy;
  logic [31:0] hi, lo, md_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .req(req),
    .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural effect of a completed operation, from plain arithmetic.
  task automatic apply_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sq, sr;
    longint unsigned up;
    case (op)
      4'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      4'd2: begin
        up = 64'(a) * 64'(b);
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      4'd3: if (b != 0) begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        m_hi = sr[31:0]; m_lo = sq[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      default: ;
    endcase
  endtask

  // Issue one mult/div op, check busy window, MFLO reads, and the commit.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int req_at, input int restart_at);
    int          n;
    logic [31:0] old_hi, old_lo;
    n      = (op <= 4'd2) ? MULT_N : DIV_N;
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    start = 1'b1; md_op = op; rs_data = a; rt_data = b; req = 1'b0;
    @(negedge clk);
    apply_model(op, a, b);
    for (int i = 1; i <= n; i++) begin
      start = 1'b0; req = 1'b0; md_op = 4'd6;
      #1;
      check("busy_window", 32'(busy), 32'd1);
      check("mflo_during_busy", md_out, old_lo);
      if (i == 4) check("hi_during_busy", hi, old_hi);
      if (i == req_at) begin
        req = 1'b1; start = 1'b1; md_op = 4'd1; rs_data = $urandom; rt_data = $urandom;
      end else if (i == restart_at) begin
        start = 1'b1; md_op = 4'd3; rs_data = $urandom; rt_data = $urandom;
      end else if (i == 5) begin
        md_op = 4'd7; rs_data = 32'hDEAD_BEEF;
      end
      @(negedge clk);
    end
    start = 1'b0; req = 1'b0; md_op = 4'd0;
    #1;
    check("busy_after_commit", 32'(busy), 32'd0);
    check("hi_commit", hi, m_hi);
    check("lo_commit", lo, m_lo);
  endtask

  // MTHI/MTLO with optional flush, then read back through MFHI/MFLO.
  task automatic mt(input logic [3:0] op, input logic [31:0] v, input logic rq);
    @(negedge clk);
    start = 1'b0; md_op = op; rs_data = v; req = rq;
    @(negedge clk);
    md_op = 4'd0; req = 1'b0;
    if (!rq) begin
      if (op == 4'd7) m_hi = v;
      else            m_lo = v;
    end
    #1;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    md_op = 4'd5; #1;
    check("mfhi", md_out, m_hi);
    md_op = 4'd6; #1;
    check("mflo", md_out, m_lo);
    md_op = 4'd0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; req = 1'b0; md_op = 4'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_md_out", md_out, 32'd0);
    reset = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check("mult_neg_hi", m_hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", m_lo, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("div_ovf_hi", hi, 32'h0000_0000);
    check("div_ovf_lo", lo, 32'h8000_0000);

    mt(4'd7, 32'h11, 1'b0);
    mt(4'd8, 32'h22, 1'b0);
    run_op(4'd4, 32'd5, 32'd0, 0, 0);
    check("divu_zero_hi", hi, 32'h11);
    check("divu_zero_lo", lo, 32'h22);
    mt(4'd8, 32'h1234, 1'b1);

    // Start squashed by flush never enters BUSY.
    @(negedge clk);
    start = 1'b1; md_op = 4'd1; rs_data = 32'd7; rt_data = 32'd9; req = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0; req = 1'b0;
    #1;
    check("req_start_busy", 32'(busy), 32'd0);
    repeat (MULT_N + 1) @(negedge clk);
    check("req_start_lo", lo, m_lo);

    run_op(4'd1, 32'h0001_2345, 32'hFFFF_0003, 2, 3);

    for (int k = 0; k < 40; k++) begin
      int          r;
      logic [3:0]  op;
      logic [31:0] a, b;
      r  = $urandom_range(0, 9);
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = $urandom;
      if (r == 5) b = 32'd0;
      if (r == 4) b = 32'($urandom_range(0, 15)) - 32'd8;
      if (r <= 5) run_op(op, a, b, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      else        mt(4'd7 + 4'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a divide aborts it with no later commit.
    mt(4'd7, 32'hAAAA, 1'b0);
    mt(4'd8, 32'h5555, 1'b0);
    @(negedge clk);
    start = 1'b1; md_op = 4'd3; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (DIV_N + 2) @(negedge clk);
    check("midrst_no_commit_busy", 32'(busy), 32'd0);
    check("midrst_no_commit_hi", hi, m_hi);
    check("midrst_no_commit_lo", lo, m_lo);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline, owning the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency and MFHI/MFLO/MTHI/MTLO in a single cycle. It produces the `busy` flag that the hazard controller combines with the EX-stage start pulse to stall any HI/LO-using instruction in ID.

## Interface

Clock and reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.

Parameters:
- `MULT_CYCLES`, default 5: busy duration of MULT/MULTU in cycles; must be ≥ 1.
- `DIV_CYCLES`, default 10: busy duration of DIV/DIVU in cycles; must be ≥ 1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: EX holds MULT/MULTU/DIV/DIVU this cycle. Also routed to the hazard controller.
- `md_op` in 4: operation code.
  - 0 = NONE
  - 1 = MULT, 2 = MULTU
  - 3 = DIV, 4 = DIVU
  - 5 = MFHI, 6 = MFLO
  - 7 = MTHI, 8 = MTLO
  - 9–15 are treated as NONE.
- `rs_data` in 32: forwarded rs operand (dividend / multiplicand / MT source).
- `rt_data` in 32: forwarded rt operand (divisor / multiplier).
- `req` in 1: exception/interrupt flush of the EX instruction this cycle.
- `busy` out 1: a multiply/divide is in flight.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.
- `md_out` out 32: MFHI/MFLO read data, combinational.

## Operation

- Two states, derived from `cnt`: IDLE (`cnt == 0`) and BUSY (`cnt != 0`).
- `busy` is `cnt != 0`. It is a registered value only; there is no combinational path from `start`.
- Accept condition: `start && !busy && !req && md_op ∈ {1,2,3,4}`.
- On accept:
  - Latch `md_op` into the pending op.
  - Compute the 64-bit result from `rs_data`/`rt_data` and latch it into `res_hi`/`res_lo`.
  - Load `cnt` with `MULT_CYCLES` for ops 1–2, or `DIV_CYCLES` for ops 3–4.
- In BUSY, `cnt` decrements each cycle. On the edge where `cnt` goes 1→0, `hi <= res_hi` and `lo <= res_lo`.
- Arithmetic:
  - MULT: `{hi,lo}` = signed 32×32 → 64.
  - MULTU: `{hi,lo}` = unsigned 32×32 → 64.
  - DIV: signed; `lo` = quotient truncated toward zero; `hi` = remainder, carrying the sign of the dividend.
  - DIV overflow: 0x80000000 / 0xFFFFFFFF gives `lo` = 0x80000000, `hi` = 0.
  - DIVU: unsigned; `lo` = quotient, `hi` = remainder.
  - Divisor 0 (DIV or DIVU): `busy` still runs the full `DIV_CYCLES`; HI and LO are left unchanged at commit.
- MTHI/MTLO: when `!busy && !req`, the next edge writes `hi` (MTHI) or `lo` (MTLO) from `rs_data`. They are ignored while busy or when `req` is high.
- `md_out`:
  - `hi` when `md_op` = 5.
  - `lo` when `md_op` = 6.
  - 0 otherwise.
  - Reads the current register value. A read during busy returns the old value; the hazard controller prevents that case.
- `start` while busy is ignored: no restart and no effect on the running operation.
- `req` squashes only the current-cycle start or MT write. An operation already in BUSY always runs to commit; this is the precise-exception rule, since that instruction has already retired past EX.

## Timing

- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `cnt` = 0, `res_hi`/`res_lo` = 0, `md_out` = 0. Asserting reset mid-operation aborts it immediately, with no commit.
- Start sampled at edge E → `busy` is 1 from E through E+N−1 (N = op latency), i.e. for exactly N cycles.
- Commit at edge E+N: `hi`/`lo` hold the new values and `busy` = 0 from E+N onward.
- A new start can be accepted at edge E+N itself; `busy` is then 0 for that cycle, and the new op starts a fresh N-cycle window.
- MTHI/MTLO latency is 1 edge. MFHI/MFLO latency is 0 (combinational).

## Test plan

- Reset, then MULT with rs = 0xFFFFFFFE (−2), rt = 3 → `busy` high for exactly 5 cycles; `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA at the 5th edge.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001.
- DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF after 10 busy cycles.
- DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIVU 5 / 0 with HI = 0x11, LO = 0x22 preloaded → `busy` still 10 cycles; HI/LO unchanged.
- MTLO 0x1234 with `req` = 1 → LO unchanged.
- Start with `req` = 1 → `busy` stays 0.
- MULT, then `req` at cycle 2 of busy → still commits.
- MFLO during `busy` → old LO returned.
- Second start at cycle 3 of busy → ignored.
- Reset asserted at cycle 3 of a DIV → `busy` = 0 and `hi` = `lo` = 0 immediately, with no later commit.
